// File: rtl/csr_row_expander.sv
// csr_row_expander: turns a CSR row-pointer stream into one row id per
// non-zero. Row descriptors (id, length) of non-empty rows are queued in a
// small FIFO; an emission engine packs them into fixed-width output beats.
module csr_row_expander #(
    parameter int OFFSET       = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int IN_PARALLEL  = 16,
    parameter int OUT_PARALLEL = 16,
    parameter int FIFO_DEPTH   = 32,
    parameter int PACK         = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_PARALLEL*DATA_WIDTH-1:0]  r_beg_data,
    input  logic                               r_beg_valid,
    input  logic                               r_beg_last,
    input  logic [IN_PARALLEL-1:0]             r_beg_bytemask,
    output logic                               r_beg_ready,
    output logic [OUT_PARALLEL*DATA_WIDTH-1:0] row_ids_data,
    output logic                               row_ids_valid,
    output logic                               row_ids_last,
    output logic [OUT_PARALLEL-1:0]            row_ids_bytemask,
    input  logic                               row_ids_ready,
    output logic                               err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OUT_PARALLEL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state;

    // Row descriptor FIFO storage and pointers (one extra wrap bit)
    logic [DATA_WIDTH-1:0] fifo_id  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_len [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           free;

    // Matrix-level pointer tracking
    logic [DATA_WIDTH-1:0] prev_ptr;
    logic [DATA_WIDTH-1:0] row_cnt;
    logic                  have_base;

    // Current partially emitted row
    logic                  cur_valid;
    logic [DATA_WIDTH-1:0] cur_id;
    logic [DATA_WIDTH-1:0] cur_rem;

    logic in_fire;
    logic end_xfer;
    logic advance;

    assign count       = wr_ptr - rd_ptr;
    assign free        = (AW+1)'(FIFO_DEPTH) - count;
    assign r_beg_ready = !rst && (free >= (AW+1)'(IN_PARALLEL)) && (state != DRAIN);
    assign in_fire     = r_beg_valid && r_beg_ready;
    assign end_xfer    = row_ids_valid && row_ids_ready && row_ids_last;
    assign advance     = !row_ids_valid || row_ids_ready;

    // Input lane walk: close rows in lane order, compact non-empty rows into FIFO slots
    logic [DATA_WIDTH-1:0] p_nxt;
    logic [DATA_WIDTH-1:0] cnt_nxt;
    logic                  hb_nxt;
    logic                  bad;
    logic [AW:0]           nwr;
    logic [DATA_WIDTH-1:0] lane;
    logic                  wr_en   [IN_PARALLEL];
    logic [AW-1:0]         wr_addr [IN_PARALLEL];
    logic [DATA_WIDTH-1:0] wr_id   [IN_PARALLEL];
    logic [DATA_WIDTH-1:0] wr_len  [IN_PARALLEL];

    always_comb begin
        p_nxt   = prev_ptr;
        cnt_nxt = row_cnt;
        hb_nxt  = have_base;
        bad     = 1'b0;
        nwr     = '0;
        lane    = '0;
        for (int i = 0; i < IN_PARALLEL; i++) begin
            wr_en[i]   = 1'b0;
            wr_addr[i] = '0;
            wr_id[i]   = '0;
            wr_len[i]  = '0;
        end
        for (int i = 0; i < IN_PARALLEL; i++) begin
            if (r_beg_bytemask[i]) begin
                lane = r_beg_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (!hb_nxt) begin
                    hb_nxt = 1'b1;
                end else begin
                    if (lane < p_nxt) begin
                        bad = 1'b1;
                    end else if (lane != p_nxt) begin
                        wr_en[i]   = 1'b1;
                        wr_addr[i] = wr_ptr[AW-1:0] + nwr[AW-1:0];
                        wr_id[i]   = DATA_WIDTH'(OFFSET) + cnt_nxt;
                        wr_len[i]  = lane - p_nxt;
                        nwr        = nwr + (AW+1)'(1);
                    end
                    cnt_nxt = cnt_nxt + DATA_WIDTH'(1);
                end
                p_nxt = lane;
            end
        end
    end

    // FIFO storage write; no reset needed since the pointers define occupancy
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < IN_PARALLEL; i++) begin
                if (wr_en[i]) begin
                    fifo_id[wr_addr[i]]  <= wr_id[i];
                    fifo_len[wr_addr[i]] <= wr_len[i];
                end
            end
        end
    end

    // Pointer tracking, write pointer and sticky error; cleared when a matrix ends
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            prev_ptr  <= '0;
            row_cnt   <= '0;
            have_base <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_ptr    <= wr_ptr + nwr;
                prev_ptr  <= p_nxt;
                row_cnt   <= cnt_nxt;
                have_base <= hb_nxt;
                if (bad) err <= 1'b1;
            end
            if (end_xfer) begin
                prev_ptr  <= '0;
                row_cnt   <= '0;
                have_base <= 1'b0;
            end
        end
    end

    // Beat builder: row A is the current row (or FIFO head), row B the next one
    logic [AW-1:0]         head_addr;
    logic [AW-1:0]         next_addr;
    logic                  a_avail;
    logic                  a_pop;
    logic [DATA_WIDTH-1:0] a_id;
    logic [DATA_WIDTH-1:0] a_rem;
    logic                  b_avail;
    logic [DATA_WIDTH-1:0] b_id;
    logic [DATA_WIDTH-1:0] b_rem;
    logic [CW-1:0]         n_a;
    logic [CW-1:0]         n_b;
    logic [CW-1:0]         room;
    logic                  use_b;
    logic [AW:0]           pops;
    logic [DATA_WIDTH-1:0] res_id;
    logic [DATA_WIDTH-1:0] res_rem;
    logic                  beat_last;
    logic [OUT_PARALLEL*DATA_WIDTH-1:0] beat_data;
    logic [OUT_PARALLEL-1:0]            beat_mask;

    assign head_addr = rd_ptr[AW-1:0];
    assign next_addr = head_addr + AW'(1);

    always_comb begin
        a_avail = cur_valid || (count != '0);
        a_pop   = !cur_valid && (count != '0);
        a_id    = cur_valid ? cur_id : fifo_id[head_addr];
        a_rem   = cur_valid ? cur_rem : (a_avail ? fifo_len[head_addr] : '0);
        b_avail = cur_valid ? (count != '0) : (count > (AW+1)'(1));
        b_id    = cur_valid ? fifo_id[head_addr]  : fifo_id[next_addr];
        b_rem   = cur_valid ? fifo_len[head_addr] : fifo_len[next_addr];

        n_a   = (a_rem >= DATA_WIDTH'(OUT_PARALLEL)) ? CW'(OUT_PARALLEL) : a_rem[CW-1:0];
        room  = CW'(OUT_PARALLEL) - n_a;
        use_b = (PACK != 0) && a_avail && (room != '0) && b_avail;
        n_b   = '0;
        if (use_b) n_b = (b_rem >= DATA_WIDTH'(room)) ? room : b_rem[CW-1:0];

        pops = (AW+1)'(a_pop) + (AW+1)'(use_b);
        if (use_b) begin
            res_id  = b_id;
            res_rem = b_rem - DATA_WIDTH'(n_b);
        end else begin
            res_id  = a_id;
            res_rem = a_rem - DATA_WIDTH'(n_a);
        end
        beat_last = (state == DRAIN) && ((count - pops) == '0) && (res_rem == '0);

        beat_data = '0;
        beat_mask = '0;
        for (int j = 0; j < OUT_PARALLEL; j++) begin
            if (CW'(j) < n_a) begin
                beat_data[j*DATA_WIDTH +: DATA_WIDTH] = a_id;
                beat_mask[j] = 1'b1;
            end else if (use_b && (CW'(j) < n_a + n_b)) begin
                beat_data[j*DATA_WIDTH +: DATA_WIDTH] = b_id;
                beat_mask[j] = 1'b1;
            end
        end
    end

    // Control FSM with the registered output beat and emission state
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            cur_valid        <= 1'b0;
            cur_id           <= '0;
            cur_rem          <= '0;
            row_ids_valid    <= 1'b0;
            row_ids_last     <= 1'b0;
            row_ids_bytemask <= '0;
            row_ids_data     <= '0;
        end else begin
            case (state)
                IDLE:    if (in_fire) state <= r_beg_last ? DRAIN : RUN;
                RUN:     if (in_fire && r_beg_last) state <= DRAIN;
                default: ;
            endcase

            if (end_xfer) begin
                state            <= IDLE;
                row_ids_valid    <= 1'b0;
                row_ids_last     <= 1'b0;
                row_ids_bytemask <= '0;
                row_ids_data     <= '0;
            end else if (advance) begin
                if (a_avail || state == DRAIN) begin
                    row_ids_valid    <= 1'b1;
                    row_ids_data     <= beat_data;
                    row_ids_bytemask <= beat_mask;
                    row_ids_last     <= beat_last;
                    rd_ptr           <= rd_ptr + pops;
                    cur_valid        <= (res_rem != '0);
                    cur_id           <= res_id;
                    cur_rem          <= res_rem;
                end else begin
                    row_ids_valid <= 1'b0;
                    row_ids_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_row_expander.sv
// Scoreboard bench for csr_row_expander: three 4-lane instances
// (PACK=1/OFFSET=0, PACK=0/OFFSET=0, PACK=1/OFFSET=100) share the input bus,
// each with its own valid and downstream ready.
module tb_csr_row_expander;

    localparam int DW = 32;
    localparam int NL = 4;

    typedef struct {
        int              dut;
        logic [NL*DW-1:0] data;
        logic [NL-1:0]   mask;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NL*DW-1:0] in_data;
    logic             in_last;
    logic [NL-1:0]    in_mask;
    logic             in_valid  [3];
    logic             in_ready  [3];
    logic [NL*DW-1:0] out_data  [3];
    logic             out_valid [3];
    logic             out_last  [3];
    logic [NL-1:0]    out_mask  [3];
    logic             out_ready [3];
    logic             err_flag  [3];

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic             hold_flag [3];
    logic [NL*DW-1:0] held_data [3];
    logic [NL-1:0]    held_mask [3];
    logic             held_last [3];

    always #5 clk = ~clk;

    csr_row_expander #(.OFFSET(0), .DATA_WIDTH(DW), .IN_PARALLEL(NL), .OUT_PARALLEL(NL),
                       .FIFO_DEPTH(8), .PACK(1)) dut_pack (
        .clk(clk), .rst(rst),
        .r_beg_data(in_data), .r_beg_valid(in_valid[0]), .r_beg_last(in_last),
        .r_beg_bytemask(in_mask), .r_beg_ready(in_ready[0]),
        .row_ids_data(out_data[0]), .row_ids_valid(out_valid[0]), .row_ids_last(out_last[0]),
        .row_ids_bytemask(out_mask[0]), .row_ids_ready(out_ready[0]), .err(err_flag[0]));

    csr_row_expander #(.OFFSET(0), .DATA_WIDTH(DW), .IN_PARALLEL(NL), .OUT_PARALLEL(NL),
                       .FIFO_DEPTH(8), .PACK(0)) dut_nopack (
        .clk(clk), .rst(rst),
        .r_beg_data(in_data), .r_beg_valid(in_valid[1]), .r_beg_last(in_last),
        .r_beg_bytemask(in_mask), .r_beg_ready(in_ready[1]),
        .row_ids_data(out_data[1]), .row_ids_valid(out_valid[1]), .row_ids_last(out_last[1]),
        .row_ids_bytemask(out_mask[1]), .row_ids_ready(out_ready[1]), .err(err_flag[1]));

    csr_row_expander #(.OFFSET(100), .DATA_WIDTH(DW), .IN_PARALLEL(NL), .OUT_PARALLEL(NL),
                       .FIFO_DEPTH(8), .PACK(1)) dut_offset (
        .clk(clk), .rst(rst),
        .r_beg_data(in_data), .r_beg_valid(in_valid[2]), .r_beg_last(in_last),
        .r_beg_bytemask(in_mask), .r_beg_ready(in_ready[2]),
        .row_ids_data(out_data[2]), .row_ids_valid(out_valid[2]), .row_ids_last(out_last[2]),
        .row_ids_bytemask(out_mask[2]), .row_ids_ready(out_ready[2]), .err(err_flag[2]));

    task automatic pushExp(input int d, input int a0, input int a1, input int a2, input int a3,
                           input logic [NL-1:0] m, input logic l);
        exp_t e;
        e.dut  = d;
        e.data = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        e.mask = m;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input int d);
        exp_t e;
        logic ok;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL beat dut%0d: unexpected beat data=%h mask=%b last=%b, required none",
                     d, out_data[d], out_mask[d], out_last[d]);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.dut == d) && (out_mask[d] == e.mask) && (out_last[d] == e.last);
        for (int j = 0; j < NL; j++)
            if (e.mask[j] && (out_data[d][j*DW +: DW] != e.data[j*DW +: DW])) ok = 1'b0;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL beat dut%0d: got data=%h mask=%b last=%b, required dut%0d data=%h mask=%b last=%b",
                     d, out_data[d], out_mask[d], out_last[d], e.dut, e.data, e.mask, e.last);
        end
    endtask

    // Monitor: compares transferring beats against the scoreboard and stalled beats for stability
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst || !out_valid[d]) begin
                hold_flag[d] = 1'b0;
            end else begin
                if (hold_flag[d]) begin
                    compared++;
                    if (out_data[d] != held_data[d] || out_mask[d] != held_mask[d] ||
                        out_last[d] != held_last[d]) begin
                        mismatched++;
                        $display("[TB] FAIL hold dut%0d: got data=%h mask=%b, required held data=%h mask=%b",
                                 d, out_data[d], out_mask[d], held_data[d], held_mask[d]);
                    end
                end
                if (out_ready[d]) begin
                    checkOutput(d);
                    hold_flag[d] = 1'b0;
                end else begin
                    hold_flag[d] = 1'b1;
                    held_data[d] = out_data[d];
                    held_mask[d] = out_mask[d];
                    held_last[d] = out_last[d];
                end
            end
        end
    end

    // Present one row-pointer beat to instance d and wait for acceptance
    task automatic applyStimulus(input int d, input int p0, input int p1, input int p2, input int p3,
                                 input logic [NL-1:0] m, input logic l);
        int   c;
        logic acc;
        in_data     = {DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
        in_mask     = m;
        in_last     = l;
        in_valid[d] = 1'b1;
        c   = 0;
        acc = 1'b0;
        while (!acc && c < 200) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
            #1;
            c++;
        end
        in_valid[d] = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept dut%0d: got no r_beg_ready in 200 cycles, required accept", d);
        end
    endtask

    task automatic waitDone(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [3:0] pat;
        rst      = 1'b1;
        in_data  = '0;
        in_mask  = '0;
        in_last  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            hold_flag[d] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        checkValue("reset_ready", 128'(in_ready[0]), 128'(0));
        checkValue("reset_valid", 128'(out_valid[0]), 128'(0));
        checkValue("reset_last",  128'(out_last[0]), 128'(0));
        checkValue("reset_mask",  128'(out_mask[0]), 128'(0));
        checkValue("reset_data",  128'(out_data[0]), 128'(0));
        checkValue("reset_err",   128'(err_flag[0]), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] packed two-row beats");
        pushExp(0, 0, 0, 1, 1, 4'b1111, 1'b0);
        pushExp(0, 1, 3, 3, 3, 4'b1111, 1'b0);
        pushExp(0, 3, 0, 0, 0, 4'b0001, 1'b1);
        applyStimulus(0, 0, 2, 5, 5, 4'b1111, 1'b0);
        applyStimulus(0, 9, 0, 0, 0, 4'b0001, 1'b1);
        waitDone("pack_done");
        checkValue("pack_err", 128'(err_flag[0]), 128'(0));

        $display("[TB] one row per beat");
        pushExp(1, 0, 0, 0, 0, 4'b0011, 1'b0);
        pushExp(1, 1, 1, 1, 0, 4'b0111, 1'b0);
        pushExp(1, 3, 3, 3, 3, 4'b1111, 1'b1);
        applyStimulus(1, 0, 2, 5, 5, 4'b1111, 1'b0);
        applyStimulus(1, 9, 0, 0, 0, 4'b0001, 1'b1);
        waitDone("nopack_done");

        $display("[TB] offset and empty-row skip");
        pushExp(2, 100, 102, 102, 102, 4'b1111, 1'b0);
        pushExp(2, 103, 103, 0, 0, 4'b0011, 1'b1);
        applyStimulus(2, 0, 1, 1, 4, 4'b1111, 1'b0);
        applyStimulus(2, 6, 0, 0, 0, 4'b0001, 1'b1);
        waitDone("offset_done");
        checkValue("offset_err", 128'(err_flag[2]), 128'(0));

        $display("[TB] long row under backpressure");
        pushExp(0, 0, 0, 0, 0, 4'b1111, 1'b0);
        pushExp(0, 0, 0, 0, 0, 4'b1111, 1'b0);
        pushExp(0, 0, 0, 0, 0, 4'b0011, 1'b1);
        applyStimulus(0, 0, 10, 0, 0, 4'b0011, 1'b1);
        pat = 4'b1001;
        for (int c = 0; c < 16; c++) begin
            if (exp_q.size() != 0) checkValue("drain_ready", 128'(in_ready[0]), 128'(0));
            out_ready[0] = pat[c % 4];
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        waitDone("stall_done");

        $display("[TB] matrix with no non-zeros");
        pushExp(0, 0, 0, 0, 0, 4'b0000, 1'b1);
        applyStimulus(0, 7, 7, 0, 0, 4'b0011, 1'b1);
        waitDone("empty_done");

        $display("[TB] decreasing pointer");
        pushExp(0, 0, 0, 0, 0, 4'b1111, 1'b0);
        pushExp(0, 0, 2, 0, 0, 4'b0011, 1'b1);
        applyStimulus(0, 0, 5, 3, 4, 4'b1111, 1'b1);
        waitDone("err_done");
        checkValue("err_set", 128'(err_flag[0]), 128'(1));

        $display("[TB] reset during drain");
        out_ready[0] = 1'b0;
        applyStimulus(0, 0, 10, 0, 0, 4'b0011, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkValue("err_sticky", 128'(err_flag[0]), 128'(1));
        checkValue("stall_valid", 128'(out_valid[0]), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        checkValue("rst_ready", 128'(in_ready[0]), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        checkValue("rst_valid", 128'(out_valid[0]), 128'(0));
        checkValue("rst_mask",  128'(out_mask[0]), 128'(0));
        checkValue("rst_data",  128'(out_data[0]), 128'(0));
        checkValue("rst_last",  128'(out_last[0]), 128'(0));
        checkValue("rst_err",   128'(err_flag[0]), 128'(0));
        @(posedge clk);
        #1;
        pushExp(0, 0, 0, 0, 0, 4'b0001, 1'b1);
        applyStimulus(0, 0, 1, 0, 0, 4'b0011, 1'b1);
        waitDone("after_rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
